fpu_sequencer: RTL
==================

# fpu_sequencer

Sequences the multi-cycle floating-point unit on behalf of pipeline stage 2. Accepts one FP instruction (ADDF/SUBF/MULF/RECF/ITOF/FTOI) with its operands, and launches it on the FPU with a one-cycle start pulse. It holds the pipeline stalled until the FPU signals done, then presents a single-cycle writeback (Rd, data, z-flag update, PC-jump flag) to the register-file/branch logic. Flush, illegal-opcode and FPU-timeout cases are handled locally.

## Interface
- TIMEOUT, 64: max cycles in WAIT before abort; legal range 2..255.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- req_valid  in  1  stage 2 presents an FP instruction.
- req_op  in  5  opcode, ir[13:9]. Legal: 0x11 ADDF, 0x12 FTOI, 0x13 ITOF, 0x14 MULF, 0x15 RECF, 0x16 SUBF.
- req_cc  in  2  condition field, ir[15:14]; S=1 requests a z update.
- req_rd  in  4  destination register.
- req_op1  in  16  Rd operand.
- req_op2  in  16  Rn/immediate operand.
- flush  in  1  squash the in-flight op (taken jump).
- stall  out  1  freezes stages 0–2.
- fpu_start  out  1  one-cycle launch pulse.
- fpu_instr  out  5  held opcode.
- fpu_op1, fpu_op2  out  16 each  held operands.
- fpu_done  in  1  FPU completion; a 1-cycle pulse or a level, sampled only in WAIT.
- fpu_result  in  16  valid in the cycle fpu_done=1.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  4  destination.
- wb_data  out  16  captured result.
- wb_setz  out  1  write z with (wb_data==0).
- wb_jump  out  1  wb_rd==15; the result is a jump target.
- err_illegal  out  1  one-cycle pulse; req_op was not a legal FP opcode.
- err_timeout  out  1  sticky; cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE, req_valid with a legal op:
  - Latch op, cc, rd, op1, op2.
  - Go to ISSUE.
- IDLE, req_valid with an illegal op:
  - Pulse err_illegal next cycle.
  - Stay in IDLE; no start is issued.
- ISSUE: fpu_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT, fpu_done=1: capture fpu_result into wb_data; go to WB.
- WAIT, watchdog reaches TIMEOUT with no done:
  - Set err_timeout.
  - Go to IDLE with no writeback; the op is lost.
- WB: wb_valid=1 for one cycle; go to IDLE.
- flush in ISSUE or WAIT: go to DRAIN.
  - ISSUE also still pulses fpu_start that cycle; the FPU must see a consistent launch.
- DRAIN: wait for fpu_done or timeout, discard the result, go to IDLE.
  - No writeback. A timeout in DRAIN also sets err_timeout.
- flush in WB: ignored; the writeback completes.
- flush in IDLE: no effect.
- wb_setz = (latched cc==1). wb_jump = (latched rd==15).
- fpu_instr/op1/op2 hold their latched values from ISSUE through the end of WAIT/DRAIN.
- stall = (state!=IDLE) | (req_valid & legal op). Combinational, so the acceptance cycle is already stalled.

## Timing
- Request accepted at edge N.
- fpu_start high during cycle N+1.
- fpu_done first sampled at edge N+2.
- fpu_done seen at edge M gives wb_valid high during cycle M+1; stall drops in cycle M+2.
- Minimum request-to-writeback: 3 cycles, with done at the first WAIT edge.
- Back-to-back: a new req is accepted at the first IDLE edge after WB; there are no bubbles beyond that.
- Watchdog: 8-bit counter, increments each WAIT/DRAIN cycle. Abort on the edge where count==TIMEOUT-1 and done=0.
- Reset, including mid-operation, forces:
  - state=IDLE.
  - stall, fpu_start, wb_valid, wb_setz, wb_jump, err_illegal, err_timeout = 0.
  - wb_rd=0, wb_data=0, fpu_instr=0, fpu_op1=0, fpu_op2=0.
- A done arriving after reset is ignored (IDLE does not sample done).

## Structure
- Shared package holds:
  - opcode constants (OPADDF..OPSUBF, matching the processor defines);
  - CC encodings (AL/S/NE/EQ);
  - FP field slices SIGN [15], EXP [14:7], MANT [6:0];
  - the state encoding.
- One sub-module, fpu_watchdog: clear/enable inputs, TIMEOUT parameter, expired output.
- Opcode legality is a package function reused by the decode in stage 1.

## Test plan
- ITOF, op2=0x0005, rd=3, cc=S; FPU done 2 cycles after start with 0x4120:
  - start pulse in cycle N+1;
  - wb_valid in cycle N+4 with rd=3, data=0x4120, setz=1, wb_jump=0;
  - stall high N..N+4.
- req_op=0x08 (ADD) → err_illegal pulse; no fpu_start; stall=0.
- MULF, flush in the second WAIT cycle, done 3 cycles later → no wb_valid; stall held until the cycle after done; the next req is accepted normally.
- TIMEOUT=4, FPU never responds → err_timeout set 4 WAIT cycles after start; state returns IDLE; err_timeout persists until reset.
- Reset asserted in WAIT → all outputs 0 the next cycle; a late fpu_done produces nothing.
- Two ADDF back-to-back, the second with rd=15 → two wb_valid pulses in order; the second has wb_jump=1.

Source files
------------

// File: rtl/fpu_sequencer_pkg.sv
// Shared definitions for the FP sequencer: opcodes, condition codes, FP field
// positions, the sequencer state encoding and the opcode legality check.
package fpu_sequencer_pkg;

    localparam logic [4:0] OPADDF = 5'h11;
    localparam logic [4:0] OPFTOI = 5'h12;
    localparam logic [4:0] OPITOF = 5'h13;
    localparam logic [4:0] OPMULF = 5'h14;
    localparam logic [4:0] OPRECF = 5'h15;
    localparam logic [4:0] OPSUBF = 5'h16;

    localparam logic [1:0] CC_AL = 2'd0;
    localparam logic [1:0] CC_S  = 2'd1;
    localparam logic [1:0] CC_NE = 2'd2;
    localparam logic [1:0] CC_EQ = 2'd3;

    localparam int FP_SIGN_BIT = 15;
    localparam int FP_EXP_MSB  = 14;
    localparam int FP_EXP_LSB  = 7;
    localparam int FP_MANT_MSB = 6;
    localparam int FP_MANT_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DRAIN = 3'd4
    } seq_state_t;

    // Also used by the stage-1 decoder to classify FP instructions.
    function automatic logic is_fp_op(input logic [4:0] op);
        return (op >= OPADDF) && (op <= OPSUBF);
    endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Cycle counter bounding how long the sequencer waits for the FPU to finish.
module fpu_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Expires on the TIMEOUT-th enabled cycle after a clear.
    assign o_expired = i_enable && (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_sequencer.sv
// Launches one FP instruction on the multi-cycle FPU, stalls stage 2 until it
// completes, and emits a single-cycle writeback; handles flush/illegal/timeout.
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [4:0]  i_req_op,
    input  logic [1:0]  i_req_cc,
    input  logic [3:0]  i_req_rd,
    input  logic [15:0] i_req_op1,
    input  logic [15:0] i_req_op2,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_fpu_start,
    output logic [4:0]  o_fpu_instr,
    output logic [15:0] o_fpu_op1,
    output logic [15:0] o_fpu_op2,
    input  logic        i_fpu_done,
    input  logic [15:0] i_fpu_result,
    output logic        o_wb_valid,
    output logic [3:0]  o_wb_rd,
    output logic [15:0] o_wb_data,
    output logic        o_wb_setz,
    output logic        o_wb_jump,
    output logic        o_err_illegal,
    output logic        o_err_timeout,
    output logic [2:0]  o_dbg_state
);

    seq_state_t  r_state;
    seq_state_t  w_next;
    logic [4:0]  r_op;
    logic [1:0]  r_cc;
    logic [3:0]  r_rd;
    logic [15:0] r_op1;
    logic [15:0] r_op2;
    logic [15:0] r_wb_data;
    logic        r_err_illegal;
    logic        r_err_timeout;
    logic        w_legal;
    logic        w_accept;
    logic        w_busy_wait;
    logic        w_expired;
    logic        w_timeout;

    // Handshake: stage 2 holds req_* while i_req_valid=1; o_stall acts as
    // not-ready, and a request is taken on the edge where stall comes only
    // from the request itself (IDLE and legal opcode).
    assign w_legal     = is_fp_op(i_req_op);
    assign w_accept    = (r_state == ST_IDLE) && i_req_valid && w_legal;
    assign w_busy_wait = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
    assign w_timeout   = w_busy_wait && !i_fpu_done && w_expired;

    fpu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (r_state == ST_ISSUE),
        .i_enable  (w_busy_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
            ST_ISSUE: w_next = i_flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                // A flush coinciding with done squashes the result outright.
                if (i_fpu_done)     w_next = i_flush ? ST_IDLE : ST_WB;
                else if (w_expired) w_next = ST_IDLE;
                else if (i_flush)   w_next = ST_DRAIN;
            end
            ST_WB:    w_next = ST_IDLE;
            ST_DRAIN: if (i_fpu_done || w_expired) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_op          <= 5'd0;
            r_cc          <= 2'd0;
            r_rd          <= 4'd0;
            r_op1         <= 16'd0;
            r_op2         <= 16'd0;
            r_wb_data     <= 16'd0;
            r_err_illegal <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_err_illegal <= (r_state == ST_IDLE) && i_req_valid && !w_legal;
            if (w_accept) begin
                r_op  <= i_req_op;
                r_cc  <= i_req_cc;
                r_rd  <= i_req_rd;
                r_op1 <= i_req_op1;
                r_op2 <= i_req_op2;
            end
            if ((r_state == ST_WAIT) && i_fpu_done && !i_flush) begin
                r_wb_data <= i_fpu_result;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign o_stall       = (r_state != ST_IDLE) || (i_req_valid && w_legal);
    assign o_fpu_start   = (r_state == ST_ISSUE);
    assign o_fpu_instr   = r_op;
    assign o_fpu_op1     = r_op1;
    assign o_fpu_op2     = r_op2;
    assign o_wb_valid    = (r_state == ST_WB);
    assign o_wb_rd       = r_rd;
    assign o_wb_data     = r_wb_data;
    assign o_wb_setz     = (r_cc == CC_S);
    assign o_wb_jump     = (r_rd == 4'd15);
    assign o_err_illegal = r_err_illegal;
    assign o_err_timeout = r_err_timeout;
    assign o_dbg_state   = r_state;

endmodule
